// File: rtl/truth_table_extractor_pkg.sv
// Shared types and defaults for the truth-table extractor.
package truth_table_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_e;

  localparam int DEF_N_IN   = 3;
  localparam int DEF_SETTLE = 1;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_extractor_if.sv
// Control/data bundle between the extractor (slave) and its controller or DUT harness (master).
interface truth_table_extractor_if #(parameter int N_IN = truth_table_pkg::DEF_N_IN);
  import truth_table_pkg::*;

  localparam int ROWS = rows(N_IN);

  logic            start;
  logic            busy;
  logic            done;
  logic [N_IN-1:0] x;
  logic            f;
  logic [ROWS-1:0] table_o;
  logic [ROWS-1:0] expected;
  logic            mismatch;
  logic [N_IN-1:0] first_bad;

  modport slave (
    input  start, f, expected,
    output busy, done, x, table_o, mismatch, first_bad
  );

  modport master (
    output start, f, expected,
    input  busy, done, x, table_o, mismatch, first_bad
  );

endinterface

// File: rtl/truth_table_extractor_first_set.sv
// Lowest-set-bit priority encoder over 2**IDX_W bits; index is 0 when nothing is set.
module tt_first_set #(
  parameter  int IDX_W = 3,
  localparam int W     = 1 << IDX_W
) (
  input  logic [W-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps x through every row, samples f after SETTLE extra cycles, publishes the table on done.
// Optional golden compare is built only when TRUTH_TABLE_COMPARE_EN is defined.
module truth_table_extractor
  import truth_table_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_extractor_if.slave bus
);

  localparam int            ROWS      = rows(N_IN);
  localparam logic [3:0]    HOLD_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [N_IN:0] LAST_ROW  = (N_IN + 1)'(ROWS - 1);
  // With no settle time each row is a single SAMPLE cycle and HOLD is skipped.
  localparam state_e        ROW_ENTRY = (SETTLE > 0) ? HOLD : SAMPLE;

  state_e          r_state;
  state_e          w_next;
  logic [N_IN:0]   r_row;
  logic [3:0]      r_cnt;
  logic [ROWS-1:0] r_shadow;
  logic [ROWS-1:0] r_table;
  logic            r_done;
  logic            w_accept;
  logic            w_last;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_row == LAST_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = ROW_ENTRY;
      HOLD:    if (r_cnt == HOLD_LAST) w_next = SAMPLE;
      SAMPLE:  w_next = w_last ? FINISH : ROW_ENTRY;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (r_state != IDLE);
    bus.x       = r_row[N_IN-1:0];
    bus.done    = r_done;
    bus.table_o = r_table;
  end

  // Row counter is one bit wider than x so the final increment never wraps onto row 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_table  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_row <= '0;
            r_cnt <= '0;
          end
        end
        HOLD:   r_cnt <= r_cnt + 4'd1;
        SAMPLE: begin
          r_shadow[r_row[N_IN-1:0]] <= bus.f;
          r_row                     <= r_row + 1'b1;
          r_cnt                     <= '0;
        end
        FINISH: begin
          r_table <= r_shadow;
          r_done  <= 1'b1;
          r_row   <= '0;
        end
        default: r_row <= '0;
      endcase
    end
  end

`ifdef TRUTH_TABLE_COMPARE_EN
  logic [ROWS-1:0] r_expected;
  logic            r_mismatch;
  logic [N_IN-1:0] r_first_bad;
  logic [N_IN-1:0] w_first_idx;
  logic            w_any_diff;

  tt_first_set #(.IDX_W(N_IN)) u_first_set (
    .i_vec   (r_shadow ^ r_expected),
    .o_idx   (w_first_idx),
    .o_found (w_any_diff)
  );

  // Compare results are published on the same edge as the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expected  <= '0;
      r_mismatch  <= 1'b0;
      r_first_bad <= '0;
    end else begin
      if (w_accept) r_expected <= bus.expected;
      if (r_state == FINISH) begin
        r_mismatch  <= w_any_diff;
        r_first_bad <= w_first_idx;
      end
    end
  end

  assign bus.mismatch  = r_mismatch;
  assign bus.first_bad = r_first_bad;
`else
  assign bus.mismatch  = 1'b0;
  assign bus.first_bad = '0;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// Scoreboard bench: two extractors (SETTLE=1 on a mux-like cell, SETTLE=0 on a parity cell).
module tb_truth_table_extractor;

`ifdef TRUTH_TABLE_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_extractor_if #(.N_IN(3)) bus0 ();
  truth_table_extractor_if #(.N_IN(3)) bus1 ();

  // Cells under characterization: f=(~x3&x1)|(x3&x2) and f=x1^x2^x3.
  assign bus0.f = (~bus0.x[2] & bus0.x[0]) | (bus0.x[2] & bus0.x[1]);
  assign bus1.f = ^bus1.x;

  truth_table_extractor #(.N_IN(3), .SETTLE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  truth_table_extractor #(.N_IN(3), .SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [7:0] tbl;
    int         done_cyc;
    logic       mm;
    logic [2:0] fb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   e0_0  = 0;
  int   k0;
  bit   chk_x = 1'b0;
  exp_t m0;
  exp_t m1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus0.done) begin
      if (q0.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dut0 unexpected done at cycle %0d", cyc);
      end else begin
        m0 = q0.pop_front();
        check("dut0 table_o", bus0.table_o, m0.tbl);
        check("dut0 done cycle", cyc, m0.done_cyc);
        check("dut0 mismatch", bus0.mismatch, m0.mm);
        check("dut0 first_bad", bus0.first_bad, m0.fb);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.done) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dut1 unexpected done at cycle %0d", cyc);
      end else begin
        m1 = q1.pop_front();
        check("dut1 table_o", bus1.table_o, m1.tbl);
        check("dut1 done cycle", cyc, m1.done_cyc);
      end
    end
  end

  // Each row is held two cycles with SETTLE=1.
  always @(negedge clk) begin
    if (chk_x && !rst) begin
      k0 = cyc - e0_0;
      if (k0 >= 0 && k0 < 16) check("dut0 x step", bus0.x, k0 / 2);
    end
  end

  task automatic go0(input logic [7:0] golden, input logic [7:0] tbl,
                     input logic mm, input logic [2:0] fb);
    bus0.expected = golden;
    bus0.start    = 1'b1;
    q0.push_back('{tbl, cyc + 1 + 17, mm, fb});
    e0_0 = cyc + 1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
  endtask

  task automatic go1(input logic [7:0] tbl);
    bus1.start = 1'b1;
    q1.push_back('{tbl, cyc + 1 + 9, 1'b0, 3'd0});
    @(posedge clk);
    #1 bus1.start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("drain timeout (pending)", q0.size() + q1.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, bus0.busy, 0);
    check({tag, " done"}, bus0.done, 0);
    check({tag, " x"}, bus0.x, 0);
    check({tag, " table_o"}, bus0.table_o, 0);
    check({tag, " mismatch"}, bus0.mismatch, 0);
    check({tag, " first_bad"}, bus0.first_bad, 0);
  endtask

  int done2;

  initial begin
    rst           = 1'b1;
    bus0.start    = 1'b0;
    bus0.expected = '0;
    bus1.start    = 1'b0;
    bus1.expected = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    go1(8'h96);
    wait_drain();

    // Golden match, with a stray start mid-sweep that must be ignored.
    @(negedge clk);
    chk_x = 1'b1;
    go0(8'hCA, 8'hCA, 1'b0, 3'd0);
    repeat (5) @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    wait_drain();
    chk_x = 1'b0;

    // Golden differs at row 2, then restart in the done cycle.
    @(negedge clk);
    go0(8'hCE, 8'hCA, CMP, CMP ? 3'd2 : 3'd0);
    done2 = e0_0 + 17;
    repeat (6) @(negedge clk);
    check("table_o held during sweep", bus0.table_o, 8'hCA);
    check("busy during sweep", bus0.busy, 1);
    for (int i = 0; i < 100 && cyc != done2; i++) @(negedge clk);
    check("reached done cycle", cyc, done2);
    check("done pulse present", bus0.done, 1);
    go0(8'hCA, 8'hCA, 1'b0, 3'd0);
    check("busy after restart in done cycle", bus0.busy, 1);
    wait_drain();

    // Reset mid-sweep discards the partial table.
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("table_o after aborted sweep", bus0.table_o, 0);
    go0(8'hCA, 8'hCA, 1'b0, 3'd0);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
